// File: rtl/sisc_regfile_sb.sv
// sisc_regfile_sb: parametrised register file with hardwired-zero R0 option, write bypass and busy-bit scoreboard (clk, rst_f, raddr/rd_en/rdata reads, we/waddr/wdata write, rsv/rsv_addr reserve, busy/hazard/stall)
module sisc_regfile_sb #(
  parameter int WIDTH = 32,
  parameter int NREG = 16,
  parameter int NRD = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic [NRD*AW-1:0]  raddr,
  input  logic [NRD-1:0]     rd_en,
  output logic [NRD*WIDTH-1:0] rdata,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               rsv,
  input  logic [AW-1:0]      rsv_addr,
  output logic [NREG-1:0]    busy,
  output logic [NRD-1:0]     hazard,
  output logic               stall
);
  logic [WIDTH-1:0] regs [NREG];
  logic wr_ok, rsv_ok;
  assign wr_ok = we && !(ZERO_R0 != 0 && waddr == '0);
  assign rsv_ok = rsv && !(ZERO_R0 != 0 && rsv_addr == '0);
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      for (int n = 0; n < NREG; n++) regs[n] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end
  genvar i;
  generate
    for (i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic fwd;
      assign ra = raddr[i*AW +: AW];
      assign fwd = BYPASS != 0 && we && waddr == ra;
      assign rdata[i*WIDTH +: WIDTH] = (ZERO_R0 != 0 && ra == '0) ? '0 : fwd ? wdata : regs[ra];
      assign hazard[i] = rd_en[i] && busy[ra] && !fwd;
    end
  endgenerate
  assign stall = |hazard;
endmodule

// File: tb/tb_sisc_regfile_sb.sv
// tb_sisc_regfile_sb: scoreboard bench driving a default instance and a 16-bit/8-reg/3-port no-zero no-bypass instance against an array model
module tb_sisc_regfile_sb;
  typedef struct packed {
    logic [127:0] rdata;
    logic [3:0]   hazard;
    logic         stall;
    logic [15:0]  busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_f = 1'b1;
  logic we = 1'b0, rsv = 1'b0;
  logic [3:0] waddr = '0, rsv_addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] ra [3];
  logic [2:0] rd_en = '0;

  logic [7:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [15:0] busy_a;
  logic [1:0]  hazard_a;
  logic        stall_a;
  logic [8:0]  raddr_b;
  logic [47:0] rdata_b;
  logic [7:0]  busy_b;
  logic [2:0]  hazard_b;
  logic        stall_b;

  assign raddr_a = {ra[1], ra[0]};
  assign raddr_b = {ra[2][2:0], ra[1][2:0], ra[0][2:0]};

  always #5 clk = ~clk;

  sisc_regfile_sb dut_a (
    .clk(clk), .rst_f(rst_f), .raddr(raddr_a), .rd_en(rd_en[1:0]), .rdata(rdata_a),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy(busy_a), .hazard(hazard_a), .stall(stall_a)
  );

  sisc_regfile_sb #(.WIDTH(16), .NREG(8), .NRD(3), .ZERO_R0(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_f(rst_f), .raddr(raddr_b), .rd_en(rd_en), .rdata(rdata_b),
    .we(we), .waddr(waddr[2:0]), .wdata(wdata[15:0]), .rsv(rsv), .rsv_addr(rsv_addr[2:0]),
    .busy(busy_b), .hazard(hazard_b), .stall(stall_b)
  );

  logic [31:0] mreg [2][16];
  logic mbusy [2][16];
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int total = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t expect_of(input int d);
    exp_t e;
    int nrd = d ? 3 : 2;
    int nreg = d ? 8 : 16;
    bit zero = (d == 0);
    bit byp = (d == 0);
    logic [31:0] mask = d ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    e = '0;
    for (int i = 0; i < nrd; i++) begin
      int a = ra[i] % nreg;
      int w = waddr % nreg;
      bit fwd = byp && we && (w == a);
      if (zero && a == 0) e.rdata[i*32 +: 32] = 32'h0;
      else if (fwd) e.rdata[i*32 +: 32] = wdata & mask;
      else e.rdata[i*32 +: 32] = mreg[d][a];
      e.hazard[i] = rd_en[i] && mbusy[d][a] && !fwd;
      e.stall = e.stall | e.hazard[i];
    end
    for (int n = 0; n < nreg; n++) e.busy[n] = mbusy[d][n];
    return e;
  endfunction

  task automatic model_edge(input int d);
    int nreg = d ? 8 : 16;
    bit zero = (d == 0);
    logic [31:0] mask = d ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    int w = waddr % nreg;
    int r = rsv_addr % nreg;
    if (we && !(zero && w == 0)) begin
      mreg[d][w] = wdata & mask;
      mbusy[d][w] = 1'b0;
    end
    if (rsv && !(zero && r == 0)) mbusy[d][r] = 1'b1;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 16; n++) begin
        mreg[d][n] = '0;
        mbusy[d][n] = 1'b0;
      end
  endtask

  task automatic step(input logic w, input int wa, input logic [31:0] wd, input logic r,
                      input int rsa, input int a0, input int a1, input int a2, input logic [2:0] en);
    @(posedge clk);
    #1;
    rst_f = 1'b0;
    we = w; waddr = wa[3:0]; wdata = wd; rsv = r; rsv_addr = rsa[3:0];
    ra[0] = a0[3:0]; ra[1] = a1[3:0]; ra[2] = a2[3:0]; rd_en = en;
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    model_edge(0);
    model_edge(1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_f = 1'b1;
    we = 1'b0; rsv = 1'b0; rd_en = '0;
    model_clear();
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_rdata0", rdata_a[31:0], ea.rdata[31:0]);
      chk("a_rdata1", rdata_a[63:32], ea.rdata[63:32]);
      chk("a_hazard", {30'b0, hazard_a}, {28'b0, ea.hazard} & 32'h3);
      chk("a_stall", {31'b0, stall_a}, {31'b0, ea.stall});
      chk("a_busy", {16'b0, busy_a}, {16'b0, ea.busy});
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_rdata0", {16'b0, rdata_b[15:0]}, eb.rdata[31:0]);
      chk("b_rdata1", {16'b0, rdata_b[31:16]}, eb.rdata[63:32]);
      chk("b_rdata2", {16'b0, rdata_b[47:32]}, eb.rdata[95:64]);
      chk("b_hazard", {29'b0, hazard_b}, {28'b0, eb.hazard} & 32'h7);
      chk("b_stall", {31'b0, stall_b}, {31'b0, eb.stall});
      chk("b_busy", {24'b0, busy_b}, {16'b0, eb.busy} & 32'hFF);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) ra[i] = '0;
    model_clear();
    do_reset();
    step(1, 3, 32'h1234, 0, 0, 3, 3, 3, 3'b000);
    step(0, 0, 0, 0, 0, 3, 3, 3, 3'b000);
    do_reset();
    step(0, 0, 0, 0, 0, 3, 3, 3, 3'b000);
    step(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 5, 3'b000);
    step(0, 0, 0, 0, 0, 5, 5, 5, 3'b000);
    step(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 3'b000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'b111);
    step(0, 0, 0, 1, 7, 0, 0, 0, 3'b000);
    step(0, 0, 0, 0, 0, 0, 7, 7, 3'b010);
    step(0, 0, 0, 0, 0, 0, 7, 7, 3'b000);
    step(1, 7, 32'h42, 0, 0, 0, 7, 7, 3'b010);
    step(0, 0, 0, 0, 0, 0, 7, 7, 3'b010);
    step(1, 9, 32'h11, 1, 9, 9, 9, 1, 3'b011);
    step(1, 4, 32'h44, 1, 2, 9, 2, 4, 3'b111);
    step(0, 0, 0, 0, 0, 2, 4, 9, 3'b111);
    step(1, 1, 32'hA5A5, 0, 0, 1, 1, 6, 3'b000);
    step(1, 6, 32'h0F0F, 0, 0, 1, 1, 6, 3'b000);
    step(0, 0, 0, 1, 6, 1, 1, 6, 3'b000);
    step(0, 0, 0, 0, 0, 1, 1, 6, 3'b100);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), 3'($urandom_range(0, 7)));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drain", qa.size() + qb.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
